blck_builder_pp_cntrl: RTL and testbench



---
 rtl/spook_bb_pkg.sv | 28 ++
 rtl/bb_slot_tracker.sv | 71 +++++++
 rtl/blck_builder_pp_cntrl.sv | 153 +++++++++++++++
 tb/tb_blck_builder_pp_cntrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spook_bb_pkg.sv
// Shared types and size helpers for the Spook ping-pong block builder.
package spook_bb_pkg;

    // Controller phases: waiting for a segment, taking input words, writing padding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PAD  = 2'd2
    } bb_state_t;

    // Flags recorded for a block when its slot closes.
    typedef struct packed {
        logic not_full;
        logic last;
    } slot_flags_t;

    // Number of bus words in one block. BLCK_SIZE must be a multiple of BUS_SIZE,
    // and the result must be at least 2.
    function automatic int bb_wpb(input int bus_size, input int blck_size);
        return blck_size / bus_size;
    endfunction

    // Width of a word index inside a block.
    function automatic int bb_widx(input int wpb);
        return (wpb > 1) ? $clog2(wpb) : 1;
    endfunction

endpackage

// File: rtl/bb_slot_tracker.sv
// Occupancy, read pointer and per-slot flags of the two-slot ping-pong buffer.
module bb_slot_tracker
    import spook_bb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        close_i,
    input  logic        close_slot_i,
    input  slot_flags_t close_flags_i,
    input  logic        ack_i,
    output logic [1:0]  occ_o,
    output logic        rdy_o,
    output logic        rd_slot_o,
    output logic        not_full_o,
    output logic        last_o
);

    logic [1:0]        occ_q, occ_d;
    logic              rd_slot_q, rd_slot_d;
    slot_flags_t [1:0] flags_q, flags_d;
    logic              rdy_q, not_full_q, last_q;
    logic              rdy_d, not_full_d, last_d;

    // Apply slot close (write side) and ack (read side); they never hit the same slot.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        occ_d     = occ_q;
        rd_slot_d = rd_slot_q;
        flags_d   = flags_q;
        if (close_i) begin
            occ_d[close_slot_i]   = 1'b1;
            flags_d[close_slot_i] = close_flags_i;
        end
        if (ack_i && occ_q[rd_slot_q]) begin
            occ_d[rd_slot_q] = 1'b0;
            rd_slot_d        = ~rd_slot_q;
        end
        // Flags are only meaningful with a ready block; keep them low otherwise.
        rdy_d      = occ_d[rd_slot_d];
        not_full_d = rdy_d & flags_d[rd_slot_d].not_full;
        last_d     = rdy_d & flags_d[rd_slot_d].last;
    end

    // Tracker state and registered read-side outputs.
    always_ff @(posedge clk) begin
        // NOTE: the flag registers are reset along with occupancy so no stale flags survive a reset.
        if (rst) begin
            occ_q      <= '0;
            rd_slot_q  <= 1'b0;
            flags_q    <= '0;
            rdy_q      <= 1'b0;
            not_full_q <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            occ_q      <= occ_d;
            rd_slot_q  <= rd_slot_d;
            flags_q    <= flags_d;
            rdy_q      <= rdy_d;
            not_full_q <= not_full_d;
            last_q     <= last_d;
        end
    end

    assign occ_o      = occ_q;
    assign rdy_o      = rdy_q;
    assign rd_slot_o  = rd_slot_q;
    assign not_full_o = not_full_q;
    assign last_o     = last_q;

endmodule

// File: rtl/blck_builder_pp_cntrl.sv
// Block builder controller: packs bus words into blocks across a two-slot ping-pong buffer.
module blck_builder_pp_cntrl
    import spook_bb_pkg::*;
#(
    parameter  int BUS_SIZE  = 32,
    parameter  int BLCK_SIZE = 256,
    localparam int WPB       = bb_wpb(BUS_SIZE, BLCK_SIZE),
    localparam int WIDX      = bb_widx(WPB)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_ready,
    input  logic            data_in_valid,
    input  logic            data_in_partial,
    input  logic            data_in_eot,
    input  logic            empty_eot,
    output logic            data_in_ready,
    output logic            en_update,
    output logic            en_padding,
    output logic            pad_first,
    output logic            wr_slot,
    output logic [WIDX-1:0] wr_idx,
    output logic            blck_out_rdy,
    output logic            blck_out_slot,
    output logic            blck_out_not_full,
    output logic            blck_out_last,
    input  logic            blck_out_ack
);

    bb_state_t       state_q, state_d;
    logic            wr_slot_q, wr_slot_d;
    logic [WIDX-1:0] wr_idx_q, wr_idx_d;
    logic            pad_pending_q, pad_pending_d;

    logic [1:0]      occ;
    logic            close;
    slot_flags_t     close_flags;
    logic            idx_last;
    logic            seg_end;

    assign idx_last = (wr_idx_q == WIDX'(WPB - 1));
    assign seg_end  = data_in_partial | data_in_eot;

    // Write-side decode: strobes to the datapath, slot close and next FSM state.
    always_comb begin
        state_d       = state_q;
        wr_slot_d     = wr_slot_q;
        wr_idx_d      = wr_idx_q;
        pad_pending_d = pad_pending_q;
        data_in_ready = 1'b0;
        en_update     = 1'b0;
        en_padding    = 1'b0;
        pad_first     = 1'b0;
        close         = 1'b0;
        close_flags   = '0;

        unique case (state_q)
            IDLE: begin
                if (set_ready) begin
                    state_d = FILL;
                end
            end

            FILL: begin
                data_in_ready = ~occ[wr_slot_q];
                en_update     = data_in_valid & data_in_ready;
                if (en_update) begin
                    // A partial word gets its 0x01 pad byte appended in the same write.
                    if (data_in_partial) begin
                        en_padding = 1'b1;
                        pad_first  = 1'b1;
                    end
                    if (idx_last) begin
                        close                = 1'b1;
                        close_flags.not_full = data_in_partial;
                        close_flags.last     = seg_end;
                        wr_idx_d             = '0;
                        wr_slot_d            = ~wr_slot_q;
                        if (seg_end) begin
                            state_d = IDLE;
                        end
                    end else begin
                        wr_idx_d = wr_idx_q + WIDX'(1);
                        if (seg_end) begin
                            state_d       = PAD;
                            pad_pending_d = ~data_in_partial;
                        end
                    end
                end else if (empty_eot && (wr_idx_q == '0)) begin
                    // Empty segment: the whole block is padding, starting with the pad byte.
                    state_d       = PAD;
                    pad_pending_d = 1'b1;
                end
            end

            PAD: begin
                // Padding waits while the slot being filled is still held by the reader.
                en_padding = ~occ[wr_slot_q];
                pad_first  = en_padding & pad_pending_q;
                if (en_padding) begin
                    pad_pending_d = 1'b0;
                    if (idx_last) begin
                        close                = 1'b1;
                        close_flags.not_full = 1'b1;
                        close_flags.last     = 1'b1;
                        wr_idx_d             = '0;
                        wr_slot_d            = ~wr_slot_q;
                        state_d              = IDLE;
                    end else begin
                        wr_idx_d = wr_idx_q + WIDX'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and write-pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_slot_q     <= 1'b0;
            wr_idx_q      <= '0;
            pad_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_slot_q     <= wr_slot_d;
            wr_idx_q      <= wr_idx_d;
            pad_pending_q <= pad_pending_d;
        end
    end

    assign wr_slot = wr_slot_q;
    assign wr_idx  = wr_idx_q;

    bb_slot_tracker u_slot_tracker (
        .clk           (clk),
        .rst           (rst),
        .close_i       (close),
        .close_slot_i  (wr_slot_q),
        .close_flags_i (close_flags),
        .ack_i         (blck_out_ack),
        .occ_o         (occ),
        .rdy_o         (blck_out_rdy),
        .rd_slot_o     (blck_out_slot),
        .not_full_o    (blck_out_not_full),
        .last_o        (blck_out_last)
    );

endmodule

// File: tb/tb_blck_builder_pp_cntrl.sv
// Self-checking bench: directed test-plan scenarios plus random traffic against a block-level model.
module tb_blck_builder_pp_cntrl;

    localparam int BUS_SIZE  = 32;
    localparam int BLCK_SIZE = 256;
    localparam int WPB       = BLCK_SIZE / BUS_SIZE;
    localparam int WIDX      = $clog2(WPB);

    localparam int M_IDLE = 0;
    localparam int M_DATA = 1;
    localparam int M_PAD  = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            set_ready = 1'b0;
    logic            data_in_valid = 1'b0;
    logic            data_in_partial = 1'b0;
    logic            data_in_eot = 1'b0;
    logic            empty_eot = 1'b0;
    logic            blck_out_ack = 1'b0;
    logic            data_in_ready;
    logic            en_update;
    logic            en_padding;
    logic            pad_first;
    logic            wr_slot;
    logic [WIDX-1:0] wr_idx;
    logic            blck_out_rdy;
    logic            blck_out_slot;
    logic            blck_out_not_full;
    logic            blck_out_last;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    blck_builder_pp_cntrl #(
        .BUS_SIZE  (BUS_SIZE),
        .BLCK_SIZE (BLCK_SIZE)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .set_ready         (set_ready),
        .data_in_valid     (data_in_valid),
        .data_in_partial   (data_in_partial),
        .data_in_eot       (data_in_eot),
        .empty_eot         (empty_eot),
        .data_in_ready     (data_in_ready),
        .en_update         (en_update),
        .en_padding        (en_padding),
        .pad_first         (pad_first),
        .wr_slot           (wr_slot),
        .wr_idx            (wr_idx),
        .blck_out_rdy      (blck_out_rdy),
        .blck_out_slot     (blck_out_slot),
        .blck_out_not_full (blck_out_not_full),
        .blck_out_last     (blck_out_last),
        .blck_out_ack      (blck_out_ack)
    );

    // Reference model: finished blocks wait in a FIFO (at most two), the block being
    // built is a slot number plus a count of words written so far.
    typedef struct {
        int slot;
        bit not_full;
        bit last;
    } blk_t;

    blk_t ready_q[$];
    int   m_mode;
    int   m_slot;
    int   m_pos;
    bit   m_pad_pending;
    int   m_rd_slot;
    bit   last_accept;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit slot_busy(input int s);
        foreach (ready_q[i]) begin
            if (ready_q[i].slot == s) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_reset();
        ready_q.delete();
        m_mode        = M_IDLE;
        m_slot        = 0;
        m_pos         = 0;
        m_pad_pending = 1'b0;
        m_rd_slot     = 0;
    endfunction

    function automatic void push_block(input bit nf, input bit lst);
        blk_t b;
        b.slot     = m_slot;
        b.not_full = nf;
        b.last     = lst;
        ready_q.push_back(b);
        m_pos  = 0;
        m_slot = m_slot ^ 1;
    endfunction

    // One clock cycle: drive inputs, compare all outputs to the model, then advance the model.
    task automatic drive_cycle(input bit sr, input bit v, input bit p, input bit e,
                               input bit ee, input bit ak, input bit r, input bit chk);
        bit busy, x_rdy_in, x_upd, x_pad, x_pf, pop;
        @(negedge clk);
        set_ready       = sr;
        data_in_valid   = v;
        data_in_partial = p;
        data_in_eot     = e;
        empty_eot       = ee;
        blck_out_ack    = ak;
        rst             = r;
        #1;
        busy     = slot_busy(m_slot);
        x_rdy_in = (m_mode == M_DATA) && !busy;
        x_upd    = x_rdy_in && v;
        x_pad    = (m_mode == M_DATA) ? (x_upd && p) : ((m_mode == M_PAD) && !busy);
        x_pf     = (m_mode == M_DATA) ? (x_upd && p) : (x_pad && m_pad_pending);
        last_accept = x_upd;
        if (chk) begin
            check("data_in_ready", 32'(data_in_ready), 32'(x_rdy_in));
            check("en_update", 32'(en_update), 32'(x_upd));
            check("en_padding", 32'(en_padding), 32'(x_pad));
            check("pad_first", 32'(pad_first), 32'(x_pf));
            check("wr_slot", 32'(wr_slot), 32'(m_slot));
            check("wr_idx", 32'(wr_idx), 32'(m_pos));
            check("blck_out_rdy", 32'(blck_out_rdy), 32'(ready_q.size() != 0));
            check("blck_out_slot", 32'(blck_out_slot), 32'(m_rd_slot));
            check("blck_out_not_full", 32'(blck_out_not_full),
                  32'((ready_q.size() != 0) ? ready_q[0].not_full : 1'b0));
            check("blck_out_last", 32'(blck_out_last),
                  32'((ready_q.size() != 0) ? ready_q[0].last : 1'b0));
        end
        @(posedge clk);
        if (r) begin
            model_reset();
            return;
        end
        pop = ak && (ready_q.size() != 0);
        case (m_mode)
            M_IDLE: begin
                if (sr) m_mode = M_DATA;
            end
            M_DATA: begin
                if (x_upd) begin
                    m_pos++;
                    if (m_pos == WPB) begin
                        push_block(p, p || e);
                        if (p || e) m_mode = M_IDLE;
                    end else if (p) begin
                        m_mode        = M_PAD;
                        m_pad_pending = 1'b0;
                    end else if (e) begin
                        m_mode        = M_PAD;
                        m_pad_pending = 1'b1;
                    end
                end else if (ee && m_pos == 0) begin
                    m_mode        = M_PAD;
                    m_pad_pending = 1'b1;
                end
            end
            M_PAD: begin
                if (x_pad) begin
                    m_pad_pending = 1'b0;
                    m_pos++;
                    if (m_pos == WPB) begin
                        push_block(1'b1, 1'b1);
                        m_mode = M_IDLE;
                    end
                end
            end
            default: m_mode = M_IDLE;
        endcase
        if (pop) begin
            void'(ready_q.pop_front());
            m_rd_slot = m_rd_slot ^ 1;
        end
    endtask

    task automatic idle_cycles(input int n, input bit ak);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, ak, 0, 1);
    endtask

    task automatic send_words(input int n, input bit end_partial, input bit end_eot);
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < 4 * n + 20) begin
            drive_cycle(0, 1, (sent == n - 1) && end_partial,
                        (sent == n - 1) && (end_eot || end_partial), 0, 0, 0, 1);
            if (last_accept) sent++;
            guard++;
        end
        check("send_words_done", 32'(sent), 32'(n));
    endtask

    initial begin
        bit sr, v, p, e, ee, ak, r;
        int sent, guard;

        model_reset();
        repeat (3) drive_cycle(0, 0, 0, 0, 0, 0, 1, 0);

        // Reset state and ignored inputs while idle.
        idle_cycles(2, 1);
        drive_cycle(0, 1, 0, 0, 1, 1, 0, 1);

        // 8 full words, eot on the last: one full, last block.
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 1);
        send_words(WPB, 0, 1);
        idle_cycles(2, 0);
        idle_cycles(2, 1);

        // 3 words, third partial + eot: padding completes the block.
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 1);
        send_words(3, 1, 1);
        idle_cycles(WPB, 0);
        idle_cycles(2, 1);

        // 3 full words, eot on the third: pad byte goes into the first pad word.
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 1);
        send_words(3, 0, 1);
        idle_cycles(WPB, 0);
        idle_cycles(2, 1);

        // Empty segment: one padding-only block.
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 1);
        drive_cycle(0, 0, 0, 0, 1, 0, 0, 1);
        idle_cycles(WPB + 2, 0);
        idle_cycles(2, 1);

        // 17 words with no ack: both slots fill and the 17th word stalls until an ack.
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 1);
        sent  = 0;
        guard = 0;
        while (sent < 2 * WPB + 1 && guard < 60) begin
            drive_cycle(0, 1, 0, 0, 0, guard == 2 * WPB + 4, 0, 1);
            if (last_accept) sent++;
            guard++;
        end
        check("stream_17_done", 32'(sent), 32'(2 * WPB + 1));

        // Reset mid-block with a slot occupied; input stays refused until set_ready.
        drive_cycle(0, 0, 0, 0, 0, 0, 1, 1);
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 1);
        send_words(WPB + 5, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 0, 1, 1);
        idle_cycles(1, 0);
        drive_cycle(0, 1, 0, 0, 0, 0, 0, 1);
        drive_cycle(0, 1, 0, 0, 0, 0, 0, 1);
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 1);
        drive_cycle(0, 1, 0, 0, 0, 0, 0, 1);
        drive_cycle(0, 0, 0, 0, 0, 0, 1, 1);

        // Random traffic with alternating heavy and light ack pressure.
        for (int i = 0; i < 4000; i++) begin
            sr = (m_mode == M_IDLE) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            v  = ($urandom_range(0, 3) != 0);
            p  = v && ($urandom_range(0, 19) == 0);
            e  = v && (p || ($urandom_range(0, 14) == 0));
            ee = !v && ($urandom_range(0, 7) == 0);
            ak = ((i / 400) % 2 == 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) == 0);
            r  = ($urandom_range(0, 999) == 0);
            drive_cycle(sr, v, p, e, ee, ak, r, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
